// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/jump codes handed to the PC, MIPS field constants
// and the fetch sequencer state encoding.
package cpu_pkg;

  typedef enum logic [6:0] {
    CODE_NONE   = 7'd0,
    CODE_BEQ    = 7'd30,
    CODE_BGEZ   = 7'd31,
    CODE_BGEZAL = 7'd32,
    CODE_BGTZ   = 7'd33,
    CODE_BLEZ   = 7'd34,
    CODE_BLTZ   = 7'd35,
    CODE_BLTZAL = 7'd36,
    CODE_BNE    = 7'd37,
    CODE_J      = 7'd38,
    CODE_JAL    = 7'd39,
    CODE_JALR   = 7'd40,
    CODE_JR     = 7'd41
  } code_def;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_EXEC1,
    ST_EXEC2,
    ST_HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Avalon-MM instruction read port between the fetch controller (master)
// and the instruction memory (slave).
interface instr_fetch_ctrl_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/branch_jump_decoder.sv
// Combinational decode of the MIPS branch/jump subset into the PC's code_def.
// Every instruction outside the subset maps to CODE_NONE.
module branch_jump_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output code_def     internal_code
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign rt            = instr[20:16];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  always_comb begin
    internal_code = CODE_NONE;
    case (op)
      OP_BEQ:  internal_code = CODE_BEQ;
      OP_BNE:  internal_code = CODE_BNE;
      OP_BLEZ: internal_code = CODE_BLEZ;
      OP_BGTZ: internal_code = CODE_BGTZ;
      OP_J:    internal_code = CODE_J;
      OP_JAL:  internal_code = CODE_JAL;
      OP_REGIMM: begin
        case (rt)
          RT_BGEZ:   internal_code = CODE_BGEZ;
          RT_BGEZAL: internal_code = CODE_BGEZAL;
          RT_BLTZ:   internal_code = CODE_BLTZ;
          RT_BLTZAL: internal_code = CODE_BLTZAL;
          default:   internal_code = CODE_NONE;
        endcase
      end
      OP_SPECIAL: begin
        case (funct)
          FUNCT_JR:   internal_code = CODE_JR;
          FUNCT_JALR: internal_code = CODE_JALR;
          default:    internal_code = CODE_NONE;
        endcase
      end
      default: internal_code = CODE_NONE;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: reads the word at the PC over Avalon-MM, registers it
// with its branch/jump decode, and steps FETCH/CAPTURE/EXEC1/EXEC2 phase strobes.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter bit          BYTE_SWAP  = 1'b1,
  parameter int unsigned RESET_IDLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               pc_address,
  input  logic                      halt,
  input  logic                      exec2_stall,
  instr_fetch_ctrl_if.master        avm,
  output logic                      fetch,
  output logic                      exec1,
  output logic                      exec2,
  output logic [31:0]               instr,
  output logic [6:0]                internal_code,
  output logic [15:0]               offset,
  output logic [25:0]               instr_index,
  output logic                      active
);

  localparam int IDLE_W = (RESET_IDLE > 1) ? $clog2(RESET_IDLE) : 1;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_done;
  logic              fetch_ok;
  logic [31:0]       capture_word;
  code_def           decoded;

  assign idle_done    = (RESET_IDLE <= 1) || (32'(idle_cnt) == RESET_IDLE - 1);
  // A misaligned PC is treated exactly like a halt request: no read is ever issued.
  assign fetch_ok     = (pc_address[1:0] == 2'b00) && !halt;
  assign capture_word = BYTE_SWAP ? swap_bytes(avm.avm_readdata) : avm.avm_readdata;

  branch_jump_decoder u_decoder (
    .instr         (capture_word),
    .internal_code (decoded)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && !idle_done)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (idle_done) state_next = ST_FETCH;
      ST_FETCH: begin
        if (!fetch_ok)
          state_next = ST_HALTED;
        else if (!avm.avm_waitrequest)
          state_next = ST_CAPTURE;
      end
      ST_CAPTURE: state_next = ST_EXEC1;
      ST_EXEC1:   state_next = ST_EXEC2;
      // halt is only looked at when EXEC2 actually retires
      ST_EXEC2:   if (!exec2_stall) state_next = halt ? ST_HALTED : ST_FETCH;
      ST_HALTED:  state_next = ST_HALTED;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Bus and strobe outputs decode straight from state so reset clears them immediately.
  always_comb begin
    avm.avm_read    = (state == ST_FETCH) && fetch_ok;
    avm.avm_address = avm.avm_read ? pc_address : 32'h0;
    fetch           = (state == ST_CAPTURE);
    exec1           = (state == ST_EXEC1);
    exec2           = (state == ST_EXEC2);
    active          = (state == ST_FETCH) || (state == ST_CAPTURE) ||
                      (state == ST_EXEC1) || (state == ST_EXEC2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr         <= '0;
      internal_code <= '0;
      offset        <= '0;
      instr_index   <= '0;
    end else if (state == ST_CAPTURE) begin
      instr         <= capture_word;
      internal_code <= decoded;
      offset        <= capture_word[15:0];
      instr_index   <= capture_word[25:0];
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl: a transaction-level model predicts each phase
// of every instruction and a rule table predicts the branch/jump decode.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        halt;
  logic        exec2_stall;
  logic        fetch, exec1, exec2;
  logic [31:0] instr;
  logic [6:0]  internal_code;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic        active;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_word;
  logic [31:0] pc;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.BYTE_SWAP(1'b1), .RESET_IDLE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_address    (pc_address),
    .halt          (halt),
    .exec2_stall   (exec2_stall),
    .avm           (bus.master),
    .fetch         (fetch),
    .exec1         (exec1),
    .exec2         (exec2),
    .instr         (instr),
    .internal_code (internal_code),
    .offset        (offset),
    .instr_index   (instr_index),
    .active        (active)
  );

  // Decode rules as (mask, match, code): the first matching rule wins, otherwise 0.
  localparam logic [31:0] RULE_MASK [12] = '{
    32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000,
    32'hFC1F0000, 32'hFC1F0000, 32'hFC1F0000, 32'hFC1F0000,
    32'hFC000000, 32'hFC000000, 32'hFC00003F, 32'hFC00003F};
  localparam logic [31:0] RULE_MATCH [12] = '{
    32'h10000000, 32'h14000000, 32'h18000000, 32'h1C000000,
    32'h04010000, 32'h04110000, 32'h04000000, 32'h04100000,
    32'h08000000, 32'h0C000000, 32'h00000008, 32'h00000009};
  localparam int RULE_CODE [12] = '{30, 37, 34, 33, 31, 32, 35, 36, 38, 39, 41, 40};

  function automatic logic [31:0] ref_code(input logic [31:0] w);
    for (int i = 0; i < 12; i++)
      if ((w & RULE_MASK[i]) == RULE_MATCH[i]) return 32'(RULE_CODE[i]);
    return 32'h0;
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'($urandom_range(0, 7));
      1: begin
        w[31:26] = 6'd1;
        w[20]    = 1'($urandom);
        w[19:17] = 3'b000;
        w[16]    = 1'($urandom);
      end
      2: begin
        w[31:26] = 6'd0;
        w[5:1]   = 5'b00100;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_strobes(input string tag, input logic [2:0] exp);
    check_eq(tag, 32'({fetch, exec1, exec2}), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_decode(input string tag, input logic [31:0] w);
    check_eq({tag, "_instr"}, instr, w);
    check_eq({tag, "_code"}, 32'(internal_code), ref_code(w));
    check_eq({tag, "_offset"}, 32'(offset), 32'(w[15:0]));
    check_eq({tag, "_index"}, 32'(instr_index), 32'(w[25:0]));
  endtask

  // Entered at posedge+1 of a cycle in which the controller is expected to be in FETCH.
  task automatic run_instr(input logic [31:0] a, input logic [31:0] word, input int waits,
                           input int stalls, input bit do_halt);
    pc_address  = a;
    halt        = 1'b0;
    exec2_stall = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      bus.avm_waitrequest = (w < waits);
      bus.avm_readdata    = $urandom;
      #1;
      check_eq("fetch_read", 32'(bus.avm_read), 32'd1);
      check_eq("fetch_addr", bus.avm_address, a);
      check_eq("fetch_active", 32'(active), 32'd1);
      check_strobes("fetch_strobes", 3'b000);
      check_decode("fetch_hold", last_word);
      step();
    end
    bus.avm_waitrequest = 1'($urandom);
    bus.avm_readdata    = swap32(word);
    halt                = 1'($urandom);
    #1;
    check_strobes("capture_strobes", 3'b100);
    check_eq("capture_read", 32'(bus.avm_read), 32'd0);
    step();
    last_word        = word;
    bus.avm_readdata = $urandom;
    halt             = 1'($urandom);
    #1;
    check_strobes("exec1_strobes", 3'b010);
    check_eq("exec1_read", 32'(bus.avm_read), 32'd0);
    check_decode("exec1", word);
    step();
    for (int s = 0; s <= stalls; s++) begin
      exec2_stall = (s < stalls);
      halt        = (s < stalls) ? 1'($urandom) : do_halt;
      #1;
      check_strobes("exec2_strobes", 3'b001);
      check_eq("exec2_active", 32'(active), 32'd1);
      check_decode("exec2_hold", word);
      step();
    end
    exec2_stall = 1'b0;
    halt        = 1'b0;
    if (do_halt) begin
      for (int k = 0; k < 20; k++) begin
        pc_address = pc + 32'd4;
        #1;
        check_eq("halted_read", 32'(bus.avm_read), 32'd0);
        check_eq("halted_active", 32'(active), 32'd0);
        check_strobes("halted_strobes", 3'b000);
        step();
      end
    end
  endtask

  // Releases reset at posedge+1 and leaves the bench at posedge+1 of the first FETCH cycle.
  task automatic release_reset();
    reset = 1'b0;
    #1;
    check_eq("idle_read", 32'(bus.avm_read), 32'd0);
    check_eq("idle_active", 32'(active), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset               = 1'b1;
    pc_address          = 32'hBFC00000;
    halt                = 1'b0;
    exec2_stall         = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'h0;
    last_word           = 32'h0;
    pc                  = 32'hBFC00000;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_read", 32'(bus.avm_read), 32'd0);
    check_eq("rst_addr", bus.avm_address, 32'h0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_strobes("rst_strobes", 3'b000);
    check_decode("rst", 32'h0);

    release_reset();
    run_instr(pc, 32'h10220004, 3, 0, 1'b0);
    check_eq("beq_offset", 32'(offset), 32'h4);

    pc = pc + 32'd4; run_instr(pc, 32'h0C000010, 0, 0, 1'b0);
    pc = pc + 32'd4; run_instr(pc, 32'h00A0F809, 0, 2, 1'b0);
    pc = pc + 32'd4; run_instr(pc, 32'h04110003, 1, 0, 1'b0);
    pc = pc + 32'd4; run_instr(pc, 32'h8C020000, 0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      pc = pc + 32'd4;
      run_instr(pc, rand_word(), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    pc = pc + 32'd4;
    run_instr(pc, rand_word(), 0, 1, 1'b1);

    reset = 1'b1;
    step();
    last_word = 32'h0;
    pc        = 32'hBFC00000;
    release_reset();
    pc_address          = pc;
    bus.avm_waitrequest = 1'b1;
    #1;
    check_eq("wait_read", 32'(bus.avm_read), 32'd1);
    step();
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_read", 32'(bus.avm_read), 32'd0);
    check_eq("abort_active", 32'(active), 32'd0);
    step();
    release_reset();
    run_instr(pc, 32'h08000123, 1, 0, 1'b0);

    pc_address = pc + 32'd6;
    #1;
    check_eq("misalign_read", 32'(bus.avm_read), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      pc_address = pc + 32'd8;
      #1;
      check_eq("misalign_halt_read", 32'(bus.avm_read), 32'd0);
      check_eq("misalign_halt_active", 32'(active), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
